// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction-memory word address, pairs each returned
// word with its PC and buffers it for decode behind a valid/ready handshake.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_sel,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          req_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] occupancy;

  // Address selection, handshake and issue throttling
  always_comb begin
    imem_sel  = redirect_valid ? redirect_target : fetch_pc_q;
    out_valid = (count_q != '0) & ~redirect_valid;
    pop       = out_valid & out_ready;
    push      = req_q & ~redirect_valid;
    // Entries held after this edge, counting the word returning now
    occupancy = count_q + CW'(req_q) - CW'(pop);
    issue     = redirect_valid | (occupancy < CW'(DEPTH));
  end

  assign out_instr = fifo_q[rd_ptr_q].instr;
  assign out_pc    = fifo_q[rd_ptr_q].pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_data};
          wr_ptr_q         <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CW'(1);
        end
      end
      if (issue) begin
        req_q      <= 1'b1;
        req_pc_q   <= imem_sel;
        fetch_pc_q <= imem_sel + PC_STEP;
      end else begin
        req_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Program-counter and fetch stage that sits directly upstream of the instruction memory.
- Drives the memory word address `sel` and captures the instruction word the memory returns one clock later.
- Pairs each instruction with its PC and hands it to decode through a small FIFO with a valid/ready handshake.
- Accepts branch/jump redirects from execute, e.g. BEQ/BNE targets computed as pc+1+sign-extended offset.

Parameters:
- RESET_PC, 32'h00000000, first word address fetched after reset.
- DEPTH, 2, fetch-buffer entries; power of two, at least 2.
- PC_STEP, 32'd1, sequential increment. The memory is word-addressed, so one instruction per address.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_sel  output  32  word address to instruction memory `sel`.
- imem_data  input  32  instruction memory `out`; valid one cycle after the address is presented.
- redirect_valid  input  1  one-cycle pulse: discard the sequential stream and fetch from redirect_target.
- redirect_target  input  32  new word address.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the entry this cycle.
- out_instr  output  32  instruction word at the FIFO head.
- out_pc  output  32  word address of out_instr.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- State:
  - fetch_pc (32).
  - req_q: a fetch is in flight.
  - req_pc_q.
  - FIFO of DEPTH {pc, instr} entries, with rd/wr pointers and count.
- Reset values:
  - fetch_pc = RESET_PC; req_q = 0; count = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0 (storage cleared).
- Address output: imem_sel = redirect_valid ? redirect_target : fetch_pc (combinational).
  - It is always driven; the memory has no enable.
- Control terms:
  - pop = out_valid & out_ready & ~redirect_valid.
  - push = req_q & ~redirect_valid. When push is set, imem_data is written with pc = req_pc_q.
- Issue rule:
  - issue = redirect_valid | (count + req_q - pop < DEPTH).
  - This guarantees no overflow and gives full throughput at DEPTH=2 (one instruction per cycle while ready).
- On issue:
  - req_q <= 1; req_pc_q <= imem_sel; fetch_pc <= imem_sel + PC_STEP.
  - The add is modulo 2^32, so 0xFFFFFFFF wraps to 0.
- No issue: req_q <= 0 and fetch_pc is held. imem_sel repeats fetch_pc and the returned data is ignored.
- Output:
  - out_valid = (count != 0) & ~redirect_valid.
  - out_instr/out_pc come from the head entry, registered storage (no combinational path from imem_data).
- Latency: address presented in cycle t, instruction is pushed at the end of t+1 and visible on out_* in t+2.
- Redirect in cycle t:
  - FIFO flushed (count <= 0, pointers reset).
  - Data arriving in t is discarded.
  - Target issued in t; out_valid = 0 in t and t+1; target instruction appears in t+2.
  - Entries presented in t are never considered consumed.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full FIFO: push cannot occur, because the issue rule prevents it. A push while full is an assertion failure in the bench.
- Back-to-back redirects: the last one wins; each flushes again.
- Priority: reset > redirect > push/pop/issue.
- Reset mid-operation: all in-flight and buffered entries are dropped; the first address after reset is RESET_PC.

Test Plan:
1. Reset, then out_ready=1 with memory model mem[a] = 0x1000_0000 + a.
   -> imem_sel = 0,1,2,… one per cycle.
   -> out_valid rises 2 cycles after reset drops.
   -> out_pc = 0,1,2,… with out_instr = 0x1000_0000+pc, no gaps.
2. Stall: out_ready=0 for 5 cycles while streaming at pc 4.
   -> out_pc holds 4 and out_valid stays 1.
   -> imem_sel stops advancing once count=DEPTH.
   -> On release, out_pc = 4,5,6,… with no loss or duplication.
3. Loop: redirect_valid pulse with target 0 in the cycle out_pc=2 is presented.
   -> out_valid=0 for 2 cycles, then out_pc=0,1,2,0,…
   -> pc 3 is never delivered.
4. Redirect while FIFO is full and out_ready=0, target 0x40.
   -> Buffer flushed; stale entries never appear.
   -> out_pc=0x40 appears 2 cycles later.
5. Wrap: RESET_PC=0xFFFFFFFE.
   -> out_pc = FFFFFFFE, FFFFFFFF, 00000000, 00000001.
6. Reset asserted mid-stream with a full FIFO and redirect_valid=1 in the same cycle.
   -> Next cycle out_valid=0, imem_sel=RESET_PC.
   -> First delivered out_pc=RESET_PC; the redirect is ignored.
